// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_pkg
//  Brief   : Shared widths, fetch FSM state codes and PC helper for instr_fetch.
//  Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int WORD_W  = 16;
  localparam int INSTR_W = 32;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h8000;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LO_RD  = 3'd1;
  localparam logic [2:0] c_LO_GAP = 3'd2;
  localparam logic [2:0] c_HI_RD  = 3'd3;
  localparam logic [2:0] c_HOLD   = 3'd4;

  // Instructions always start on an even word.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] i_addr);
    return {i_addr[WORD_W-1:1], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_rd_timer.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_rd_timer
//  Brief   : Counts rd-high cycles of one word read; flags the sampling cycle.
//  Revision: 1.0 - initial release
// ============================================================================
module fetch_rd_timer #(
  parameter int RD_WAIT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_abort,
  output logic o_sample
);

  localparam int              CNT_W  = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CNT_W-1:0] c_load = CNT_W'(RD_WAIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_run;

  assign w_run    = i_start && !i_abort;
  assign o_sample = w_run && (r_cnt == '0);

  // An abort reloads the count so the restarted word gets a full rd window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= c_load;
    end else if (!w_run || o_sample) begin
      r_cnt <= c_load;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : instr_fetch
//  Brief   : Two-word EPROM fetch, {opcode, operand} assembly, valid/ready out.
//  Revision: 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                RD_WAIT  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [WORD_W-1:0]  address_bus,
  output logic               rd,
  input  logic [WORD_W-1:0]  data_bus,
  input  logic               inta,
  input  logic               redirect_valid,
  input  logic [WORD_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [WORD_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               misalign
);

  logic [2:0]         r_state;
  logic [WORD_W-1:0]  r_pc;
  logic [WORD_W-1:0]  r_lo;
  logic [INSTR_W-1:0] r_instr;
  logic [WORD_W-1:0]  r_instr_pc;
  logic               r_misalign;
  logic               w_reading;
  logic               w_odd_word;
  logic               w_sample;

  assign w_reading  = (r_state == c_LO_RD) || (r_state == c_HI_RD);
  assign w_odd_word = (r_state == c_LO_GAP) || (r_state == c_HI_RD);

  fetch_rd_timer #(
    .RD_WAIT (RD_WAIT)
  ) u_rd_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_reading),
    .i_abort  (inta),
    .o_sample (w_sample)
  );

  // pc[0] is always 0, so the odd word address is a bit set, not an add.
  assign address_bus = w_odd_word ? {r_pc[WORD_W-1:1], 1'b1} : r_pc;
  assign rd          = w_reading && !inta;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == c_HOLD);
  assign misalign    = r_misalign;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= c_IDLE;
      r_pc       <= RESET_PC;
      r_lo       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && redirect_pc[0];
      if (redirect_valid) begin
        r_state <= c_IDLE;
        r_pc    <= align_pc(redirect_pc);
      end else begin
        case (r_state)
          c_IDLE: begin
            if (!inta) r_state <= c_LO_RD;
          end
          c_LO_RD: begin
            if (w_sample) begin
              r_lo    <= data_bus;
              r_state <= c_LO_GAP;
            end
          end
          c_LO_GAP: begin
            r_state <= c_HI_RD;
          end
          c_HI_RD: begin
            if (w_sample) begin
              r_instr    <= {data_bus, r_lo};
              r_instr_pc <= r_pc;
              r_state    <= c_HOLD;
            end
          end
          c_HOLD: begin
            // rd is already low here, so the next read can start immediately.
            if (instr_ready) begin
              r_pc    <= r_pc + 16'd2;
              r_state <= c_LO_RD;
            end
          end
          default: begin
            r_state <= c_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_instr_fetch
//  Brief   : Self-checking bench for instr_fetch with an EPROM model on data_bus.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int RD_WAIT = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] address_bus;
  logic        rd;
  logic [15:0] data_bus;
  logic        inta;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign;

  logic [15:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;
  bit en       = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EPROM drives the bus only while selected and strobed.
  assign data_bus = (rd && !inta) ? mem[address_bus] : 16'hDEAD;

  instr_fetch #(
    .RESET_PC (16'h8000),
    .RD_WAIT  (RD_WAIT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_bus    (address_bus),
    .rd             (rd),
    .data_bus       (data_bus),
    .inta           (inta),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .misalign       (misalign)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch progress is one counter t over the instruction:
  // t in [0,RD_WAIT) reads the even word, t==RD_WAIT is the gap,
  // t in (RD_WAIT, 2*RD_WAIT] reads the odd word; m_valid means waiting on the consumer.
  bit          m_idle, m_valid, m_mis;
  int          m_t;
  logic [15:0] m_pc, m_ipc, m_lo;
  logic [31:0] m_instr;

  task automatic m_outputs(output logic e_rd, output logic [15:0] e_addr);
    e_rd   = 1'b0;
    e_addr = m_pc;
    if (!m_idle && !m_valid) begin
      if (m_t < RD_WAIT) begin
        e_rd = !inta;
      end else begin
        e_addr = m_pc + 16'd1;
        e_rd   = (m_t > RD_WAIT) && !inta;
      end
    end
  endtask

  task automatic model_step();
    logic        r;
    logic [15:0] a, d;
    m_outputs(r, a);
    d = mem[a];
    if (!reset_n) begin
      m_idle = 1'b1; m_valid = 1'b0; m_mis = 1'b0; m_t = 0;
      m_pc = 16'h8000; m_ipc = 16'h0000; m_instr = 32'h0; m_lo = 16'h0;
    end else begin
      m_mis = redirect_valid && redirect_pc[0];
      if (redirect_valid) begin
        m_idle = 1'b1; m_valid = 1'b0; m_t = 0;
        m_pc = redirect_pc & 16'hFFFE;
      end else if (m_idle) begin
        if (!inta) begin m_idle = 1'b0; m_t = 0; end
      end else if (m_valid) begin
        if (instr_ready) begin m_valid = 1'b0; m_pc = m_pc + 16'd2; m_t = 0; end
      end else if (m_t < RD_WAIT) begin
        if (inta) m_t = 0;
        else begin
          if (m_t == RD_WAIT - 1) m_lo = d;
          m_t++;
        end
      end else if (m_t == RD_WAIT) begin
        m_t++;
      end else if (inta) begin
        m_t = RD_WAIT + 1;
      end else if (m_t == 2 * RD_WAIT) begin
        m_instr = {d, m_lo}; m_ipc = m_pc; m_valid = 1'b1;
      end else begin
        m_t++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic        er;
    logic [15:0] ea;
    @(negedge clk);
    if (en) begin
      m_outputs(er, ea);
      chk("rd", 32'(rd), 32'(er));
      chk("address_bus", 32'(address_bus), 32'(ea));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("misalign", 32'(misalign), 32'(m_mis));
      if (m_valid) begin
        chk("instr", instr, m_instr);
        chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic next_valid();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!instr_valid && n < 60);
    if (!instr_valid) chk("wait_instr_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_hi_rd();
    int n = 0;
    while (!(rd && address_bus[0]) && n < 60) begin
      cyc();
      n++;
    end
    if (!(rd && address_bus[0])) chk("wait_hi_rd_timeout", 32'(rd), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(address_bus), 32'h8000);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, 32'(instr_pc), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h8000] = 16'h8000; mem[16'h8001] = 16'h4801;
    mem[16'h8042] = 16'h8006; mem[16'h8043] = 16'h0000;
    mem[16'hFFFE] = 16'h1234; mem[16'hFFFF] = 16'hABCD;

    reset_n = 1'b0; inta = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0; instr_ready = 1'b1;
    cyc();
    en = 1'b1;
    cyc(2);
    chk_reset_vals("reset");

    // Release and first-fetch timeline.
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 1 || k == 2) chk($sformatf("c%0d_lo", k), {15'h0, rd, address_bus}, {16'h1, 16'h8000});
      if (k == 3) chk("c3_gap_rd", 32'(rd), 32'd0);
      if (k == 4 || k == 5) chk($sformatf("c%0d_hi", k), {15'h0, rd, address_bus}, {16'h1, 16'h8001});
      chk($sformatf("c%0d_valid", k), 32'(instr_valid), 32'(k == 6));
      if (k == 6) begin
        chk("c6_instr", instr, 32'h4801_8000);
        chk("c6_instr_pc", 32'(instr_pc), 32'h8000);
      end
      if (k == 7) chk("c7_next_lo", {15'h0, rd, address_bus}, {16'h1, 16'h8002});
    end

    next_valid();
    chk("stream_pc1", 32'(instr_pc), 32'h8002);
    next_valid();
    chk("stream_pc2", 32'(instr_pc), 32'h8004);

    // Consumer stall in HOLD.
    instr_ready = 1'b0;
    cyc(10);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_pc", 32'(instr_pc), 32'h8004);
    chk("stall_rd", 32'(rd), 32'd0);
    instr_ready = 1'b1;
    cyc();
    chk("after_xfer_lo", {15'h0, rd, address_bus}, {16'h1, 16'h8006});

    // Redirect during the odd-word read.
    wait_hi_rd();
    redirect_valid = 1'b1; redirect_pc = 16'h8042;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_rd", 32'(rd), 32'd0);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    next_valid();
    chk("redir_instr", instr, 32'h0000_8006);
    chk("redir_pc", 32'(instr_pc), 32'h8042);

    // Misaligned redirect, then interrupt acknowledge mid read.
    redirect_valid = 1'b1; redirect_pc = 16'h8043;
    cyc();
    redirect_valid = 1'b0;
    chk("misalign_pulse", 32'(misalign), 32'd1);
    cyc();
    chk("misalign_clear", 32'(misalign), 32'd0);
    inta = 1'b1;
    cyc(3);
    chk("inta_rd_low", 32'(rd), 32'd0);
    inta = 1'b0;
    next_valid();
    chk("inta_instr", instr, 32'h0000_8006);
    chk("inta_pc", 32'(instr_pc), 32'h8042);

    // PC wrap.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    next_valid();
    chk("wrap_pc0", 32'(instr_pc), 32'hFFFE);
    chk("wrap_instr", instr, 32'hABCD_1234);
    next_valid();
    chk("wrap_pc1", 32'(instr_pc), 32'h0000);

    // Reset in the middle of a read.
    wait_hi_rd();
    reset_n = 1'b0;
    cyc();
    chk_reset_vals("midreset");
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h8000 | 16'($urandom_range(0, 255)));
      inta           = ($urandom_range(0, 15) == 0);
      reset_n        = ($urandom_range(0, 999) != 0);
      cyc();
    end
    inta = 1'b0; redirect_valid = 1'b0; reset_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
